// File: rtl/fmul_pkg.sv
// Shared definitions for the float-multiply sharing stage: FP width, constants
// and the pipeline slot carried alongside each product.
package fmul_pkg;

  localparam int FP_W     = 32;
  localparam int ID_W_MAX = 4;   // wide enough for up to 16 requesters

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
    logic [FP_W-1:0]     data;
  } slot_t;

endpackage

// File: rtl/FloatMult.sv
// Combinational IEEE-754 single multiply: round-to-nearest-even, subnormal
// inputs and results flush to signed zero, overflow and inf/nan inputs give signed inf.
module FloatMult
  import fmul_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] p
);

  logic        sign;
  logic [47:0] mprod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic        guard;
  logic        sticky;
  logic        round_up;
  int          e_sum;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sign     = a[31] ^ b[31];
    mprod    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e_sum    = int'(a[30:23]) + int'(b[30:23]) - 127;
    mant     = mprod[45:23];
    guard    = mprod[22];
    sticky   = |mprod[21:0];
    if (mprod[47]) begin
      mant   = mprod[46:24];
      guard  = mprod[23];
      sticky = |mprod[22:0];
      e_sum  = e_sum + 1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    if (mant_r[23]) e_sum = e_sum + 1;

    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      p = {sign, 31'd0};
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || e_sum >= 255)
      p = {sign, 8'hFF, 23'd0};
    else if (e_sum <= 0)
      p = {sign, 31'd0};
    else
      p = {sign, e_sum[7:0], mant_r[22:0]};
  end

endmodule

// File: rtl/fmul_rr_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Reusable by any stage that shares one resource among N requesters.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id
);

  logic found;
  int   idx;

  // NOTE: blocking assignments here are intentional: 'found' must be visible
  // to later loop iterations within the same evaluation.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (advance) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/fmul_rr_arbiter.sv
// Shares one FloatMult among N_REQ requesters with round-robin issue and a
// PIPE_STAGES-deep result pipeline that stalls as a whole on backpressure.
module fmul_rr_arbiter
  import fmul_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [FP_W-1:0]       res_data
);

  slot_t           pipe [PIPE_STAGES];
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;
  logic            advance;
  logic            issue;
  logic [FP_W-1:0] op_a;
  logic [FP_W-1:0] op_b;
  logic [FP_W-1:0] prod;

  assign advance = !res_valid || res_ready;
  assign issue   = |req_ready;

  // Gating with rst_n keeps req_ready low for the whole reset cycle.
  rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_arb (
    .req      (req_valid),
    .advance  (advance && rst_n),
    .ptr      (ptr),
    .grant    (req_ready),
    .grant_id (grant_id)
  );

  always_comb begin
    op_a = FP_ZERO;
    op_b = FP_ZERO;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        op_a = req_a[FP_W*i +: FP_W];
        op_b = req_b[FP_W*i +: FP_W];
      end
    end
  end

  FloatMult u_fmul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // NOTE: the pipeline is only a few slots wide, so every slot is reset; this
  // also guarantees in-flight products are dropped and res_data reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) pipe[s] <= '0;
    end else if (advance) begin
      pipe[0].valid <= issue;
      pipe[0].id    <= ID_W_MAX'(grant_id);
      pipe[0].data  <= issue ? prod : FP_ZERO;
      for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
      if (issue)
        ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  assign res_valid = pipe[PIPE_STAGES-1].valid;
  assign res_id    = pipe[PIPE_STAGES-1].id[ID_W-1:0];
  assign res_data  = pipe[PIPE_STAGES-1].data;

endmodule

// File: tb/tb_fmul_rr_arbiter.sv
// Directed bench for fmul_rr_arbiter: latency, round robin, wrap, backpressure,
// zero operand and mid-flight reset, all with hand-computed expectations.
module tb_fmul_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [31:0]  res_data;

  int total = 0;
  int bad   = 0;

  // lane i operand a = (i+1).0, b = 2.0, so product = 2*(i+1)
  logic [31:0] lane_a [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] lane_p [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  fmul_rr_arbiter #(.N_REQ(4), .ID_W(2), .PIPE_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lanes();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = lane_a[i];
      req_b[32*i +: 32] = 32'h40000000;
    end
  endtask

  task automatic check_res(input string tag, input logic [1:0] id, input logic [31:0] data);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_id"},    32'(res_id),    32'(id));
    check({tag, "_data"},  res_data,       data);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    res_ready = 1'b1;
    load_lanes();

    // reset: outputs cleared and no grant while rst_n is low
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_id",    32'(res_id),    32'd0);
    check("rst_data",  res_data,       32'd0);

    // latency: 2.0 * 3.0 on lane 0, result two cycles after issue
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    #1 check("lat_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    check("lat_t1_valid", 32'(res_valid), 32'd0);
    step();
    check_res("lat_t2", 2'd0, 32'h40C00000);
    step();
    check("lat_t3_valid", 32'(res_valid), 32'd0);

    // round robin from ptr=0 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    load_lanes();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) check_res("rr_res", 2'((k - 2) % 4), lane_p[(k - 2) % 4]);
      step();
    end
    req_valid = 4'h0;
    check_res("rr_tail6", 2'd2, lane_p[2]);
    step();
    check_res("rr_tail7", 2'd3, lane_p[3]);
    step();
    check("rr_drain", 32'(res_valid), 32'd0);

    // wrap: move ptr to 3 by granting lane 2, then lanes 3 and 0 alternate
    req_valid = 4'b0100;
    #1 check("wrap_pre", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1001;
    #1 check("wrap_g3a", 32'(req_ready), 32'b1000);
    step();
    #1 check("wrap_g0a", 32'(req_ready), 32'b0001);
    step();
    #1 check("wrap_g3b", 32'(req_ready), 32'b1000);
    step();
    #1 check("wrap_g0b", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1011;
    #1 check("wrap_g1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    step();

    // backpressure: hold the first result for 5 cycles, then drain in order
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b0111;
    step();
    step();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_ready", 32'(req_ready), 32'd0);
      check_res("bp_hold", 2'd0, lane_p[0]);
      step();
    end
    res_ready = 1'b1;
    #1 check("bp_release_grant", 32'(req_ready), 32'b0100);
    check_res("bp_rel0", 2'd0, lane_p[0]);
    step();
    req_valid = 4'b0000;
    check_res("bp_rel1", 2'd1, lane_p[1]);
    step();
    check_res("bp_rel2", 2'd2, lane_p[2]);
    step();
    check("bp_drain", 32'(res_valid), 32'd0);

    // zero operand: 0 * -2.0 gives -0.0
    req_a[63:32] = 32'h00000000;
    req_b[63:32] = 32'hC0000000;
    req_valid = 4'b0010;
    #1 check("zero_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    check_res("zero_res", 2'd1, 32'h80000000);
    step();

    // reset with two products in flight (ptr=2: lanes 2 then 3 issue)
    load_lanes();
    req_valid = 4'hF;
    #1 check("mid_g2", 32'(req_ready), 32'b0100);
    step();
    #1 check("mid_g3", 32'(req_ready), 32'b1000);
    step();
    rst_n = 1'b0;
    #1 check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    check("mid_valid", 32'(res_valid), 32'd0);
    check("mid_data",  res_data,       32'd0);
    check("mid_id",    32'(res_id),    32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1110;
    #1 check("mid_lowest", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    check("mid_gone", 32'(res_valid), 32'd0);
    step();
    check_res("mid_next", 2'd1, lane_p[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
